// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter sharing one synchronous-read memory among NUM_REQ requesters.
// One read in flight at a time: ARB -> ISSUE -> WAIT -> RESP, fixed 4-cycle turnaround.
module mem_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      rerr,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_ptr, r_owner;
    logic                r_oor;
    logic [NUM_REQ-1:0]  r_gnt, r_rvalid;
    logic                r_rerr;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_maddr;

    logic                w_found;
    logic [PW-1:0]       w_win, w_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_oor;

    // Scan ptr+1, ptr+2, ... so the last winner has lowest priority next time.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_addr = addr[w_win*ADDR_W +: ADDR_W];
        w_oor  = (int'(w_addr) >= MEM_DEPTH);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB:     if (w_found) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = RESP;
            RESP:    w_next = ARB;
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ARB;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= PW'(NUM_REQ - 1);
            r_owner  <= '0;
            r_oor    <= 1'b0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
            r_maddr  <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_rerr   <= 1'b0;
            case (r_state)
                ARB: if (w_found) begin
                    r_gnt   <= NUM_REQ'(1) << w_win;
                    r_owner <= w_win;
                    r_oor   <= w_oor;
                    r_maddr <= w_oor ? '0 : w_addr;
                end
                WAIT: begin
                    r_rdata  <= r_oor ? '0 : mem_rdata;
                    r_rvalid <= NUM_REQ'(1) << r_owner;
                    r_rerr   <= r_oor;
                end
                RESP:    r_ptr <= r_owner;
                default: ;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign rerr     = r_rerr;
    assign rdata    = r_rdata;
    assign mem_addr = r_maddr;
    assign busy     = (r_state != ARB);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: a transaction-level model predicts grant slots,
// rotating priority and returned data from a 16-word memory preloaded with 3*i.
module tb_mem_read_arbiter;
    localparam int N = 4, AW = 4, DW = 8, DEPTH = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt, rvalid;
    logic            rerr, busy;
    logic [DW-1:0]   rdata, mem_rdata;
    logic [AW-1:0]   mem_addr;

    logic [DW-1:0]   mem [16];

    mem_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rvalid(rvalid),
        .rerr(rerr), .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: n = rising edges since reset release, A = edge of the last arbitration win.
    int            n, next_arb, A, ptr, win;
    logic [N-1:0]  m_oh;
    logic [DW-1:0] cur_data, prev_data;
    logic [AW-1:0] cur_ma, prev_ma;
    logic          cur_err;

    task automatic model_reset();
        n = 0; next_arb = 1; A = -100; ptr = N - 1; win = 0; m_oh = '0;
        cur_data = '0; prev_data = '0; cur_ma = '0; prev_ma = '0; cur_err = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
        int a;
        req = rq; addr = ad;
        if (n + 1 == next_arb) begin
            if (rq == '0) next_arb++;
            else begin
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (ptr + k) % N;
                    if (win < 0 && ((rq >> idx) & 1) != 0) win = idx;
                end
                A = n + 1; next_arb = A + 4; ptr = win;
                prev_data = cur_data; prev_ma = cur_ma;
                a = int'(AW'(ad >> (win * AW)));
                cur_err  = (a >= DEPTH);
                cur_data = cur_err ? '0 : DW'(3 * a);
                cur_ma   = cur_err ? '0 : AW'(a);
                m_oh     = N'(1) << win;
            end
        end
        @(posedge clk); n++; @(negedge clk);
        chk("gnt",      32'(gnt),      (n == A)     ? 32'(m_oh) : 32'd0);
        chk("rvalid",   32'(rvalid),   (n == A + 2) ? 32'(m_oh) : 32'd0);
        chk("rerr",     32'(rerr),     (n == A + 2) ? 32'(cur_err) : 32'd0);
        chk("rdata",    32'(rdata),    (n >= A + 2) ? 32'(cur_data) : 32'(prev_data));
        chk("busy",     32'(busy),     32'(n >= A && n <= A + 2));
        chk("mem_addr", 32'(mem_addr), (n >= A) ? 32'(cur_ma) : 32'(prev_ma));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);       chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rerr", 32'(rerr), 0);     chk("rst_rdata", 32'(rdata), 0);
        chk("rst_maddr", 32'(mem_addr), 0); chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < cycles; i++) begin
            req = N'($urandom); addr = (N*AW)'($urandom);
            @(negedge clk);
            chk("rst_hold_gnt", 32'(gnt), 0);
            chk("rst_hold_busy", 32'(busy), 0);
        end
        model_reset();
        req = '0;
        rst = 1'b1;
    endtask

    task automatic align();
        for (int i = 0; i < 8 && n + 1 != next_arb; i++) step('0, '0);
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) step('0, '0);
    endtask

    logic [N-1:0]    pend;
    logic [N*AW-1:0] paddr;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(3 * i);
        req = '0; addr = '0;
        model_reset();

        // reset with random requests, first grant to lowest active index
        do_reset(3);
        step(N'($urandom_range(1, (1 << N) - 1)), (N*AW)'($urandom));
        idle(4);

        // round-robin from a fresh reset
        do_reset(1);
        for (int i = 0; i < 20; i++) step(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1});
        idle(4);

        // single read
        align();
        step(4'b0001, 16'h0005); step('0, '0); step('0, '0);
        chk("single_rdata", 32'(rdata), 32'd15);
        idle(2);

        // out-of-range
        align();
        step(4'b0100, 16'h0C00); step('0, '0); step('0, '0);
        chk("oor_rerr", 32'(rerr), 32'd1);
        idle(2);

        // reset during WAIT, then a clean read by requester 1
        align();
        step(4'b0100, 16'h0300); step('0, '0);
        do_reset(2);
        step(4'b0010, 16'h0070);
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        idle(4);

        // requester 3 drops req right after its grant
        align();
        step(4'b1000, 16'h9000); idle(6);

        // randomized traffic, requests held until the model grants them
        pend = '0; paddr = '0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    paddr[i*AW +: AW] = AW'($urandom_range(0, 15));
                end
            step(pend, paddr);
            if (n == A) begin
                pend[win] = 1'(($urandom_range(0, 1)));
                if (pend[win]) paddr[win*AW +: AW] = AW'($urandom_range(0, 15));
            end
            if (it == 200) begin
                do_reset(1);
                pend = '0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
